// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register file geometry and the
// architecturally special register indices used by the RegDst mux
// (rt/rd/ra select) and the control unit.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_reg_file_rf_read_port.sv
// One combinational read port of the register file: index mux over the
// register view, hard zero for index 0, and an optional same-cycle bypass
// of the data being written.
module rf_read_port #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] data
);

  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic hit;

  // Bypass only applies to real writes to a non-zero register.
  assign hit = BYPASS_EN && reg_write && (write_reg == addr) && (addr != ZERO_IDX);

  // Select: zero register first, then bypass, then stored contents.
  always_comb begin
    data = '0;
    if (addr == ZERO_IDX) begin
      data = '0;
    end else if (hit) begin
      data = write_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read
// ports, one debug read port and one synchronous write port. Register 0 is
// never stored; it reads as zero everywhere.
module mips_reg_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_a,
  input  logic [ADDR_W-1:0] read_reg_b,
  output logic [DATA_W-1:0] read_data_a,
  output logic [DATA_W-1:0] read_data_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2**ADDR_W;

  // Storage for registers 1..DEPTH-1 only; index 0 has no flops.
  logic [DATA_W-1:0] mem  [1:DEPTH-1];
  // Full-width read view with a constant zero in slot 0.
  logic [DATA_W-1:0] view [DEPTH];

  // Write port: reset clears everything asynchronously and wins over a
  // write; each register compares its own index so an unknown index with
  // reg_write low can never reach any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (reg_write && (write_reg == ADDR_W'(i))) begin
          mem[i] <= write_data;
        end
      end
    end
  end

  // Build the read view seen by all ports.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = mem[i];
    end
  end

  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(BYPASS_EN)
  ) u_port_a (
    .regs      (view),
    .addr      (read_reg_a),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .data      (read_data_a)
  );

  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(BYPASS_EN)
  ) u_port_b (
    .regs      (view),
    .addr      (read_reg_b),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .data      (read_data_b)
  );

  // Debug port always shows the committed contents, never the bypass.
  rf_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(1'b0)
  ) u_port_dbg (
    .regs      (view),
    .addr      (dbg_addr),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .data      (dbg_data)
  );

endmodule

// File: tb/tb_mips_reg_file.sv
// Self-checking bench for mips_reg_file: directed corner sequences, a
// table of write/read vectors, and random traffic against an array model.
module tb_mips_reg_file;

  localparam bit BYP = 1'b0;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_a;
  logic [4:0]  read_reg_b;
  logic [31:0] read_data_a;
  logic [31:0] read_data_b;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [7];

  mips_reg_file #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .BYPASS_EN(BYP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg_a (read_reg_a),
    .read_reg_b (read_reg_b),
    .read_data_a(read_data_a),
    .read_data_b(read_data_b),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] r, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = r;
    write_data = d;
    tick();
    reg_write  = 1'b0;
  endtask

  // Every register through the debug port against a reference array.
  task automatic sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check(name, dbg_data, (i == 0) ? 32'h0 : model[i]);
    end
  endtask

  task automatic clear_model;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] ea, eb;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg_a = '0;
    read_reg_b = '0;
    dbg_addr   = '0;
    clear_model();

    tick();
    tick();
    sweep("reset_sweep");
    reset = 1'b0;

    // Basic write/read on both ports
    do_write(5'd7, 32'h0000_0001);
    read_reg_a = 5'd7;
    read_reg_b = 5'd7;
    #1;
    check("basic_a", read_data_a, 32'h1);
    check("basic_b", read_data_b, 32'h1);

    // Table of write-then-read vectors (reads taken after the edge)
    vecs[0] = '{1'b1, 5'd5,  32'h0000_0005, 5'd5,  5'd5,  32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{1'b0, 5'd5,  32'h0000_0077, 5'd5,  5'd0,  32'h0000_0005, 32'h0000_0000};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd7,  32'hCAFE_F00D, 32'h0000_0001};
    vecs[4] = '{1'b1, 5'd29, 32'h0000_1234, 5'd29, 5'd31, 32'h0000_1234, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 5'd5,  32'h0000_0055, 5'd5,  5'd29, 32'h0000_0055, 32'h0000_1234};
    vecs[6] = '{1'b0, 5'd0,  32'h0000_0000, 5'd7,  5'd5,  32'h0000_0001, 32'h0000_0055};
    for (int i = 0; i < 7; i++) begin
      reg_write  = vecs[i].rw;
      write_reg  = vecs[i].wr;
      write_data = vecs[i].wd;
      tick();
      reg_write  = 1'b0;
      read_reg_a = vecs[i].ra;
      read_reg_b = vecs[i].rb;
      #1;
      check($sformatf("vec%0d_a", i), read_data_a, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), read_data_b, vecs[i].exp_b);
    end

    // Zero register: a write to r0 is dropped, debug also reads 0
    do_write(5'd0, 32'hFFFF_FFFF);
    read_reg_a = 5'd0;
    dbg_addr   = 5'd0;
    #1;
    check("r0_read", read_data_a, 32'h0);
    check("r0_dbg", dbg_data, 32'h0);

    // r0 also reads 0 while a write to r0 is pending
    reg_write  = 1'b1;
    write_reg  = 5'd0;
    write_data = 32'h1357_9BDF;
    read_reg_a = 5'd0;
    read_reg_b = 5'd0;
    #1;
    check("r0_pending_a", read_data_a, 32'h0);
    check("r0_pending_b", read_data_b, 32'h0);
    reg_write = 1'b0;

    // Read-during-write
    do_write(5'd9, 32'h10);
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'h20;
    read_reg_a = 5'd9;
    read_reg_b = 5'd0;
    dbg_addr   = 5'd9;
    #1;
    check("rdw_pre_a", read_data_a, BYP ? 32'h20 : 32'h10);
    check("rdw_pre_b_r0", read_data_b, 32'h0);
    check("rdw_pre_dbg", dbg_data, 32'h10);
    tick();
    reg_write = 1'b0;
    #1;
    check("rdw_post_a", read_data_a, 32'h20);

    // Asynchronous reset mid-cycle
    do_write(5'd8, 32'hDEAD_BEEF);
    read_reg_a = 5'd8;
    #1;
    check("pre_reset_r8", read_data_a, 32'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    check("async_reset_r8", read_data_a, 32'h0);
    clear_model();
    sweep("async_reset_sweep");

    // Reset held across an edge with a write presented
    reg_write  = 1'b1;
    write_reg  = 5'd3;
    write_data = 32'hA5;
    tick();
    reg_write  = 1'b0;
    #2;
    reset      = 1'b0;
    read_reg_a = 5'd3;
    #1;
    check("reset_vs_write_r3", read_data_a, 32'h0);

    // First write after mid-cycle reset release lands on the next edge
    do_write(5'd3, 32'h3333_0000);
    #1;
    check("post_reset_write_r3", read_data_a, 32'h3333_0000);
    model[3] = 32'h3333_0000;

    // Randomised traffic against the array model
    for (int n = 0; n < 400; n++) begin
      reg_write  = 1'($urandom_range(0, 1));
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg_a = 5'($urandom_range(0, 31));
      read_reg_b = (n % 5 == 0) ? read_reg_a : 5'($urandom_range(0, 31));
      dbg_addr   = 5'($urandom_range(0, 31));
      #1;
      ea = (read_reg_a == 0) ? 32'h0 :
           (BYP && reg_write && write_reg == read_reg_a) ? write_data : model[read_reg_a];
      eb = (read_reg_b == 0) ? 32'h0 :
           (BYP && reg_write && write_reg == read_reg_b) ? write_data : model[read_reg_b];
      check("rand_a", read_data_a, ea);
      check("rand_b", read_data_b, eb);
      check("rand_dbg", dbg_data, (dbg_addr == 0) ? 32'h0 : model[dbg_addr]);
      tick();
      if (reg_write && write_reg != 0) model[write_reg] = write_data;
    end
    reg_write = 1'b0;

    // Unknown write controls with reg_write low must not disturb anything
    write_reg  = 'x;
    write_data = 'x;
    tick();
    tick();
    sweep("xsafe_sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
